// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type and encodings,
// common to uart_tx and a future uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLK_DIV-1, wraps, and flags the
// last cycle of each serial bit with tick.
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB first, optional parity
// (macro UART_TX_PARITY_EN), STOP_BITS stop bits; txd_o registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 tx_vld_i,
    output logic                 tx_rdy_o,
    input  logic [DATA_BITS-1:0] tx_data_i,
    output logic                 txd_o,
    output logic                 busy_o
);

    localparam int BIT_W = $clog2(DATA_BITS);

    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        !(STOP_BITS == 1 || STOP_BITS == 2) ||
        !(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_param_err
        $error("uart_tx: illegal parameter value");
    end

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 txd_q, txd_d;
    logic                 tick, accept, last_stop;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clear  (state_q == IDLE),
        .tick   (tick)
    );

    assign last_stop = (state_q == STOP) && tick &&
                       (bit_cnt_q == BIT_W'(STOP_BITS - 1));
    assign accept    = tx_vld_i && tx_rdy_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            IDLE: ;
            START: if (tick) begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d   = PARITY;
`else
                    state_d   = STOP;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP: if (last_stop) begin
                state_d = IDLE;
            end else if (tick) begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        // a byte accepted in the final stop cycle starts the next frame directly
        if (accept) begin
            state_d   = START;
            shift_d   = tx_data_i;
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            par_d     = (^tx_data_i) ^ PARITY_ODD[0];
`endif
        end
    end

    always_comb begin
        tx_rdy_o = (state_q == IDLE) || last_stop;
        busy_o   = (state_q != IDLE);
        txd_d    = 1'b1;
        unique case (state_d)
            START:  txd_d = 1'b0;
            DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    assign txd_o = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits), table vectors,
// random streams and a mid-frame reset, against a frame-level model.
module tb_uart_tx;

    localparam int CD = 4;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       vld_a = 1'b0, vld_b = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic       rdy_a, rdy_b, txd_a, txd_b, busy_a, busy_b;
    logic       txd, rdy, busy;
    bit         sel = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(CD), .DATA_BITS(DB), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk_i(clk), .rstn_i(rstn), .tx_vld_i(vld_a), .tx_rdy_o(rdy_a),
        .tx_data_i(data_a), .txd_o(txd_a), .busy_o(busy_a)
    );

    uart_tx #(.CLK_DIV(CD), .DATA_BITS(DB), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
        .clk_i(clk), .rstn_i(rstn), .tx_vld_i(vld_b), .tx_rdy_o(rdy_b),
        .tx_data_i(data_b), .txd_o(txd_b), .busy_o(busy_b)
    );

    always_comb begin
        txd  = sel ? txd_b  : txd_a;
        rdy  = sel ? rdy_b  : rdy_a;
        busy = sel ? busy_b : busy_a;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: bit index 0 start, 1..DB payload LSB first,
    // then parity if enabled, then stop bits (1).
    function automatic logic exp_bit(input logic [7:0] d, input int idx,
                                     input bit odd);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
        if (P == 1 && idx == DB + 1) return (^d) ^ odd;
        return 1'b1;
    endfunction

    function automatic int frame_len(input bit s);
        return (1 + DB + P + (s ? 2 : 1)) * CD;
    endfunction

    task automatic drive(input bit v, input logic [7:0] d);
        if (sel) begin vld_b = v; data_b = d; end
        else     begin vld_a = v; data_a = d; end
    endtask

    // Sends q back-to-back with valid held high; payload input is
    // scrambled right after each acceptance.
    task automatic stream(input bit s, input logic [7:0] q[$], input int exp_busy);
        int f;
        int busy_cnt;
        sel      = s;
        f        = frame_len(s);
        busy_cnt = 0;
        @(negedge clk);
        check("idle_rdy", rdy, 1);
        drive(1'b1, q[0]);
        for (int k = 0; k < q.size(); k++) begin
            for (int c = 0; c < f; c++) begin
                @(negedge clk);
                check("txd", txd, exp_bit(q[k], c / CD, s));
                check("rdy", rdy, (c == f - 1));
                busy_cnt += int'(busy);
                if (c == 0) drive(1'b1, ~q[k]);
                if (c == f - 1) begin
                    if (k + 1 < q.size()) drive(1'b1, q[k+1]);
                    else                  drive(1'b0, 8'hFF);
                end
            end
        end
        @(negedge clk);
        check("end_txd", txd, 1);
        check("end_busy", busy, 0);
        check("end_rdy", rdy, 1);
        check("busy_cycles", busy_cnt, exp_busy);
    endtask

    typedef struct {
        bit         s;
        logic [7:0] d0;
        logic [7:0] d1;
        int         n;
        int         busy;
    } vec_t;

    initial begin
        vec_t       vecs[6];
        logic [7:0] q[$];
        int         bad;

        vecs[0] = '{1'b0, 8'h55, 8'h00, 1, 40 + 4 * P};
        vecs[1] = '{1'b0, 8'hA5, 8'h3C, 2, 80 + 8 * P};
        vecs[2] = '{1'b0, 8'h07, 8'h00, 1, 40 + 4 * P};
        vecs[3] = '{1'b1, 8'h07, 8'h00, 1, 44 + 4 * P};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1, 40 + 4 * P};
        vecs[5] = '{1'b1, 8'h80, 8'h00, 1, 44 + 4 * P};

        repeat (3) @(negedge clk);
        check("rst_txd_a", txd_a, 1);
        check("rst_rdy_a", rdy_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_txd_b", txd_b, 1);
        check("rst_rdy_b", rdy_b, 1);
        check("rst_busy_b", busy_b, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            q = {};
            q.push_back(vecs[i].d0);
            if (vecs[i].n > 1) q.push_back(vecs[i].d1);
            stream(vecs[i].s, q, vecs[i].busy);
        end

        for (int r = 0; r < 8; r++) begin
            bit s;
            int n;
            s = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            q = {};
            for (int j = 0; j < n; j++) q.push_back(8'($urandom));
            stream(s, q, n * frame_len(s));
        end

        // reset pulse during data bit 3 of a 0x00 frame
        sel = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'h00);
        for (int c = 0; c <= 4 * CD + 1; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b0, 8'h00);
        end
        check("pre_rst_txd", txd_a, 0);
        check("pre_rst_busy", busy_a, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_txd", txd_a, 1);
        check("rst_async_busy", busy_a, 0);
        check("rst_async_rdy", rdy_a, 1);
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        for (int c = 0; c < 15 * CD; c++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        q = {};
        q.push_back(8'h3C);
        stream(1'b0, q, 40 + 4 * P);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, clk_i cycles per serial bit, legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame, legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense (0 = even, 1 = odd); meaningful only with UART_TX_PARITY_EN.
REQ-005 SHALL have clk_i  input  1  clock.
REQ-006 SHALL have rstn_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have tx_vld_i  input  1  upstream byte valid.
REQ-008 SHALL have tx_rdy_o  output  1  block can accept a byte.
REQ-009 SHALL have tx_data_i  input  DATA_BITS  payload.
REQ-010 SHALL have txd_o  output  1  serial line, idle high, registered.
REQ-011 SHALL have busy_o  output  1  frame in progress (state != IDLE).

Function
REQ-012 SHALL use an FSM with states IDLE, START, DATA, PARITY, STOP; PARITY is entered only when UART_TX_PARITY_EN is defined.
REQ-013 SHALL accept a byte on the cycle tx_vld_i && tx_rdy_o, latching tx_data_i into a shift register; later changes on tx_data_i are ignored.
REQ-014 SHALL drive tx_rdy_o high in IDLE, and in the final clk_i cycle of the last stop bit; low otherwise (combinational from state and counters).
REQ-015 SHALL drive txd_o low (start bit) starting the cycle after acceptance; 1 cycle latency from handshake to line.
REQ-016 SHALL hold each bit for exactly CLK_DIV clk_i cycles via a baud counter of width $clog2(CLK_DIV) that counts 0..CLK_DIV-1 and wraps to 0.
REQ-017 SHALL transmit: start bit (0), data LSB first (DATA_BITS bits), optional parity, STOP_BITS stop bits (1).
REQ-018 SHALL count data bits with a counter of width $clog2(DATA_BITS) and leave DATA after bit DATA_BITS-1 completes.
REQ-019 SHALL produce a total frame of (1+DATA_BITS+P+STOP_BITS)*CLK_DIV cycles, where P = 1 with parity and 0 without.
REQ-020 SHALL support back-to-back frames: an acceptance in the final stop cycle goes directly to START with no idle cycle.
REQ-021 SHALL, on reaching the end of stop with no new byte, return to IDLE with txd_o = 1.
REQ-022 SHALL hold tx_rdy_o low for the whole of START, DATA and PARITY regardless of tx_vld_i.
REQ-023 SHALL never deassert busy_o between back-to-back frames.

Reset
REQ-024 SHALL, while rstn_i is low, force: state IDLE, txd_o = 1, tx_rdy_o = 1, busy_o = 0, all counters and the shift register to 0.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame immediately (txd_o = 1 asynchronously) and not resume it after release.

Configuration
REQ-026 SHALL compile the parity bit in only when macro UART_TX_PARITY_EN is defined.
REQ-027 SHALL, with the macro, send after the data bits one bit equal to XOR(data) ^ PARITY_ODD, lasting CLK_DIV cycles.
REQ-028 SHALL, without the macro, go from DATA directly to STOP, contain no parity logic, and ignore PARITY_ODD.

Structure
REQ-029 SHALL take the FSM state typedef (uart_state_t) and the state encodings from the shared package uart_pkg, for reuse by a future uart_rx.
REQ-030 SHALL implement the baud counter and its per-bit tick as the sub-module uart_baud_tick (parameter CLK_DIV; inputs clk_i, rstn_i, clear; output tick).
REQ-031 SHALL reject illegal CLK_DIV, DATA_BITS or STOP_BITS values with an elaboration-time check.

Verification
REQ-032 SHALL cover: CLK_DIV=4, DATA_BITS=8, no parity, send 0x55 -> txd_o = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total, then tx_rdy_o = 1.
REQ-033 SHALL cover: 0xA5 then 0x3C with tx_vld_i held high -> second start bit immediately after first stop bit, busy_o continuously 1, 80 cycles total.
REQ-034 SHALL cover: UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame 44 cycles.
REQ-035 SHALL cover: tx_data_i changed to 0xFF mid-frame after accepting 0x00 -> line still shows 0x00 payload.
REQ-036 SHALL cover: rstn_i pulsed low during data bit 3 -> txd_o = 1 same cycle, busy_o = 0, no further edges until next handshake.
REQ-037 SHALL cover: STOP_BITS=2, send 0x80 -> two 4-cycle high stop bits before tx_rdy_o returns high (tx_rdy_o high in the last stop cycle).
